// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store controller.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   localparam int unsigned TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store-lane replication, alignment check and
// load-lane extraction/extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        sext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] mem_rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = mem_rdata_i[{off_i, 3'b000} +: 8];
   assign half_lane = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = wdata_i;
      misalign_o = 1'b0;
      rdata_o    = mem_rdata_i;
      case (size_i)
         SZ_B: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{sext_i & byte_lane[7]}}, byte_lane};
         end
         SZ_H: begin
            be_o       = 4'b0011 << off_i;
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = off_i[0];
            rdata_o    = {{16{sext_i & half_lane[15]}}, half_lane};
         end
         SZ_W: begin
            be_o       = 4'b1111;
            misalign_o = |off_i;
         end
         default: misalign_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access at a time, req/ack memory handshake,
// alignment checking, ack timeout and formatted load return.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e      state_q, state_d;
   lsu_req_t    rq_q, rq_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        mis_q, mis_d;
   logic        to_q, to_d;
   logic [31:0] rdata_q, rdata_d;

   logic        in_idle, in_req, in_resp;
   logic [1:0]  al_size, al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;
   logic        al_mis;

   assign in_idle = (state_q == ST_IDLE);
   assign in_req  = (state_q == ST_REQ);
   assign in_resp = (state_q == ST_RESP);

   // In IDLE the aligner checks the incoming request; afterwards it works
   // from the registered copy so the memory side stays stable.
   assign al_size = in_idle ? size       : rq_q.size;
   assign al_off  = in_idle ? addr[1:0]  : rq_q.addr[1:0];

   lsu_align u_align (
      .size_i      (al_size),
      .off_i       (al_off),
      .sext_i      (rq_q.sext),
      .wdata_i     (rq_q.wdata),
      .mem_rdata_i (mem_rdata),
      .be_o        (al_be),
      .wdata_o     (al_wdata),
      .misalign_o  (al_mis),
      .rdata_o     (al_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rq_q    <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rq_q    <= rq_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rq_d    = rq_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      to_d    = to_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               rq_d    = '{we: we, size: size, sext: sext, addr: addr, wdata: wdata};
               cnt_d   = '0;
               mis_d   = al_mis;
               to_d    = 1'b0;
               state_d = al_mis ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               if (!rq_q.we) rdata_d = al_rdata;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               to_d    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory-side outputs are forced to zero outside REQ so reset and idle
   // present a quiet bus.
   assign mem_req   = in_req;
   assign mem_we    = in_req & rq_q.we;
   assign mem_be    = in_req ? al_be : 4'b0000;
   assign mem_addr  = in_req ? {rq_q.addr[31:2], 2'b00} : 32'h0;
   assign mem_wdata = in_req ? al_wdata : 32'h0;

   assign busy     = ~in_idle;
   assign done     = in_resp;
   assign misalign = in_resp & mis_q;
   assign timeout  = in_resp & to_q;
   assign rdata    = rdata_q;

endmodule
